// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared match-state encoding and screen geometry/colour constants
//            for the Pong datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GOAL_HOLD = 2'd2,
        GAME_OVER = 2'd3
    } match_state_t;

    // Screen, border, paddle and ball geometry in pixels
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BORDER_W  = 8;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int PADDLE_X0 = 32;
    localparam int PADDLE_X1 = SCREEN_W - 32 - PADDLE_W;
    localparam int BALL_SIZE = 8;

    // 12-bit RGB444 colours
    localparam logic [11:0] COLOUR_BG     = 12'h000;
    localparam logic [11:0] COLOUR_BORDER = 12'hFFF;
    localparam logic [11:0] COLOUR_PADDLE = 12'h0F0;
    localparam logic [11:0] COLOUR_BALL   = 12'hFF0;
    localparam logic [11:0] COLOUR_SCORE  = 12'h0FF;

endpackage

`default_nettype wire

// File: rtl/pong_win_check.sv
// ============================================================================
// Module   : pong_win_check
// Purpose  : Combinational win test for one candidate player against the
//            (already updated) score vector. PONG_WIN_BY_TWO_EN selects the
//            win-by-two rule with saturation fallback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pong_win_check
    import pong_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int SCORE_W     = 4,
    parameter  int WIN_SCORE   = 9,
    localparam int PW          = $clog2(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS*SCORE_W-1:0] scores_i,
    input  logic [PW-1:0]                  cand_i,
    output logic                           win_o
);

`ifdef PONG_WIN_BY_TWO_EN
    logic [SCORE_W-1:0] cand_score;
    logic [SCORE_W-1:0] other;
    logic               lead_ok;
    logic               highest;

    always_comb begin
        cand_score = '0;
        other      = '0;
        lead_ok    = 1'b1;
        highest    = 1'b1;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (PW'(i) == cand_i) begin
                cand_score = scores_i[i*SCORE_W +: SCORE_W];
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            other = scores_i[i*SCORE_W +: SCORE_W];
            if (PW'(i) != cand_i) begin
                // Extra bit keeps other+2 from wrapping near saturation
                if ({1'b0, cand_score} < ({1'b0, other} + (SCORE_W+1)'(2))) begin
                    lead_ok = 1'b0;
                end
                if ((other > cand_score) || ((other == cand_score) && (PW'(i) < cand_i))) begin
                    highest = 1'b0;
                end
            end
        end
        win_o = ((cand_score >= SCORE_W'(WIN_SCORE)) && lead_ok) ||
                ((cand_score == '1) && highest);
    end
`else
    always_comb begin
        win_o = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((PW'(i) == cand_i) && (scores_i[i*SCORE_W +: SCORE_W] == SCORE_W'(WIN_SCORE))) begin
                win_o = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/pong_match_controller.sv
// ============================================================================
// Module   : pong_match_controller
// Purpose  : Match/score sequencer (SERVE/PLAY/GOAL_HOLD/GAME_OVER) with
//            edge-qualified goal counting. Optional PONG_WIN_BY_TWO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pong_match_controller
    import pong_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int SCORE_W     = 4,
    parameter  int WIN_SCORE   = 9,
    parameter  int HOLD_CYCLES = 16,
    localparam int PW          = $clog2(NUM_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic [NUM_PLAYERS-1:0]         goal,
    input  logic                           ball_served,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [PW:0]                    winner,
    output logic                           game_over,
    output logic [PW-1:0]                  server,
    output logic                           goal_pulse,
    output logic                           in_play
);

    localparam int                 HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    match_state_t                   state_q, state_d;
    logic [NUM_PLAYERS-1:0]         goal_prev_q;
    logic [NUM_PLAYERS-1:0]         rise;
    logic [HW-1:0]                  hold_cnt_q, hold_cnt_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d, scores_inc;
    logic [PW:0]                    winner_q, winner_d;
    logic [PW-1:0]                  server_q, server_d;
    logic                           goal_pulse_q, goal_pulse_d;
    logic [PW-1:0]                  k;
    logic                           win;

    assign rise = goal & ~goal_prev_q;

    // Simultaneous rises award a single point to the lowest index
    always_comb begin
        k = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                k = PW'(i);
            end
        end
    end

    always_comb begin
        scores_inc = scores_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((PW'(i) == k) && (scores_q[i*SCORE_W +: SCORE_W] != SCORE_MAX)) begin
                scores_inc[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
        end
    end

    pong_win_check #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .SCORE_W     (SCORE_W),
        .WIN_SCORE   (WIN_SCORE)
    ) u_win_check (
        .scores_i (scores_inc),
        .cand_i   (k),
        .win_o    (win)
    );

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        scores_d     = scores_q;
        winner_d     = winner_q;
        server_d     = server_q;
        goal_pulse_d = 1'b0;
        case (state_q)
            SERVE: begin
                if (ball_served) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (|rise) begin
                    scores_d     = scores_inc;
                    goal_pulse_d = 1'b1;
                    server_d     = (k == PW'(NUM_PLAYERS - 1)) ? '0 : k + PW'(1);
                    hold_cnt_d   = '0;
                    if (win) begin
                        state_d  = GAME_OVER;
                        winner_d = {1'b0, k} + (PW+1)'(1);
                    end else begin
                        state_d  = GOAL_HOLD;
                    end
                end
            end
            GOAL_HOLD: begin
                if (|goal) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_cnt_d = '0;
                    state_d    = SERVE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            GAME_OVER: begin
            end
            default: begin
                state_d = SERVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= SERVE;
            goal_prev_q  <= '0;
            hold_cnt_q   <= '0;
            scores_q     <= '0;
            winner_q     <= '0;
            server_q     <= '0;
            goal_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            goal_prev_q  <= goal;
            hold_cnt_q   <= hold_cnt_d;
            scores_q     <= scores_d;
            winner_q     <= winner_d;
            server_q     <= server_d;
            goal_pulse_q <= goal_pulse_d;
        end
    end

    assign scores     = scores_q;
    assign winner     = winner_q;
    assign server     = server_q;
    assign goal_pulse = goal_pulse_q;
    assign game_over  = (state_q == GAME_OVER);
    assign in_play    = (state_q == PLAY);

endmodule

`default_nettype wire

// File: tb/tb_pong_match_controller.sv
// ============================================================================
// Module   : tb_pong_match_controller
// Purpose  : Self-checking bench for pong_match_controller (2 players,
//            4-bit scores, win at 9, 16-cycle hold). Honours PONG_WIN_BY_TWO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pong_match_controller;

    localparam int NP = 2;
    localparam int SW = 4;
    localparam int WS = 9;
    localparam int HC = 16;

    logic       clk = 1'b0;
    logic       Reset;
    logic [1:0] goal;
    logic       ball_served;
    logic [7:0] scores;
    logic [1:0] winner;
    logic       game_over;
    logic       server;
    logic       goal_pulse;
    logic       in_play;

    pong_match_controller #(
        .NUM_PLAYERS (NP),
        .SCORE_W     (SW),
        .WIN_SCORE   (WS),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .goal        (goal),
        .ball_served (ball_served),
        .scores      (scores),
        .winner      (winner),
        .game_over   (game_over),
        .server      (server),
        .goal_pulse  (goal_pulse),
        .in_play     (in_play)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sc;
        logic [1:0] win;
        logic       over;
        logic       srv;
        logic       pulse;
        logic       play;
    } out_t;

    typedef struct {
        logic       rst;
        logic [1:0] g;
        logic       s;
        out_t       exp;
    } vec_t;

    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model of the match rules
    int         m_state;   // 0 serve, 1 play, 2 hold, 3 over
    int         m_hold;
    int         m_sc[2];
    int         m_win;
    int         m_srv;
    logic [1:0] m_prev;
    logic       m_pulse;

    function automatic bit model_wins(input int k);
        int o;
        o = 1 - k;
`ifdef PONG_WIN_BY_TWO_EN
        return ((m_sc[k] >= WS) && (m_sc[k] - m_sc[o] >= 2)) ||
               ((m_sc[k] == 15) && ((m_sc[k] > m_sc[o]) || ((m_sc[k] == m_sc[o]) && (k < o))));
`else
        return m_sc[k] == WS;
`endif
    endfunction

    task automatic model_step(input logic rst, input logic [1:0] g, input logic s);
        logic [1:0] rise;
        int         k;
        m_pulse = 1'b0;
        if (rst) begin
            m_state = 0; m_prev = 2'b00; m_hold = 0;
            m_sc[0] = 0; m_sc[1] = 0; m_win = 0; m_srv = 0;
            return;
        end
        rise = g & ~m_prev;
        case (m_state)
            0: if (s) m_state = 1;
            1: if (rise != 2'b00) begin
                k = rise[0] ? 0 : 1;
                if (m_sc[k] < 15) m_sc[k]++;
                m_pulse = 1'b1;
                m_srv   = (k + 1) % 2;
                if (model_wins(k)) begin
                    m_state = 3;
                    m_win   = k + 1;
                end else begin
                    m_state = 2;
                    m_hold  = 0;
                end
            end
            2: if (g != 2'b00) m_hold = 0;
               else begin
                   m_hold++;
                   if (m_hold == HC) begin
                       m_state = 0;
                       m_hold  = 0;
                   end
               end
            default: ;
        endcase
        m_prev = g;
    endtask

    function automatic out_t model_out();
        out_t e;
        e.sc    = {4'(m_sc[1]), 4'(m_sc[0])};
        e.win   = 2'(m_win);
        e.over  = (m_state == 3);
        e.srv   = 1'(m_srv);
        e.pulse = m_pulse;
        e.play  = (m_state == 1);
        return e;
    endfunction

    function automatic out_t dut_out();
        return {scores, winner, game_over, server, goal_pulse, in_play};
    endfunction

    function automatic out_t mk(input logic [7:0] sc, input logic srv, input logic p, input logic ip);
        out_t e;
        e.sc = sc; e.win = 2'd0; e.over = 1'b0; e.srv = srv; e.pulse = p; e.play = ip;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle; expected value queued at drive time, compared after the edge
    task automatic cyc_e(input logic rst, input logic [1:0] g, input logic s,
                         input bit use_tbl, input out_t tbl_exp, input string name);
        out_t got, want;
        Reset = rst; goal = g; ball_served = s;
        model_step(rst, g, s);
        exp_q.push_back(use_tbl ? tbl_exp : model_out());
        @(posedge clk);
        #1;
        got  = dut_out();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got sc=%h win=%0d over=%0b srv=%0d pulse=%0b play=%0b, expected sc=%h win=%0d over=%0b srv=%0d pulse=%0b play=%0b",
                     name, got.sc, got.win, got.over, got.srv, got.pulse, got.play,
                     want.sc, want.win, want.over, want.srv, want.pulse, want.play);
        end
    endtask

    task automatic cyc(input logic rst, input logic [1:0] g, input logic s, input string name);
        cyc_e(rst, g, s, 1'b0, '0, name);
    endtask

    task automatic rearm();
        repeat (HC) cyc(1'b0, 2'b00, 1'b0, "hold");
        cyc(1'b0, 2'b00, 1'b1, "serve");
    endtask

    task automatic point(input logic [1:0] g);
        cyc(1'b0, g, 1'b0, "point");
        rearm();
    endtask

    vec_t tbl[11];

    initial begin
        Reset = 1'b1; goal = 2'b00; ball_served = 1'b0;

        tbl[0]  = '{1'b1, 2'b00, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = '{1'b0, 2'b10, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1)};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1)};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1)};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, mk(8'h01, 1'b1, 1'b1, 1'b0)};
        tbl[6]  = '{1'b0, 2'b01, 1'b0, mk(8'h01, 1'b1, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 2'b01, 1'b0, mk(8'h01, 1'b1, 1'b0, 1'b0)};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, mk(8'h01, 1'b1, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 2'b01, 1'b0, mk(8'h01, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, 2'b01, 1'b1, mk(8'h01, 1'b1, 1'b0, 1'b0)};

        for (int i = 0; i < 11; i++) begin
            cyc_e(tbl[i].rst, tbl[i].g, tbl[i].s, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Hold: 15 clear, one goal, then the full 16-cycle clear run is needed
        repeat (15) cyc(1'b0, 2'b00, 1'b1, "hold15");
        cyc(1'b0, 2'b01, 1'b1, "hold_goal");
        for (int i = 0; i < 17; i++) begin
            cyc(1'b0, 2'b00, 1'b1, "hold16");
            chk($sformatf("serve_timing%0d", i), int'(in_play), int'(i == 16));
        end

        // Simultaneous rise
        cyc(1'b0, 2'b11, 1'b0, "simul");
        chk("simul_p0", int'(scores[3:0]), 2);
        chk("simul_p1", int'(scores[7:4]), 0);
        chk("simul_srv", int'(server), 1);
        chk("simul_pulse", int'(goal_pulse), 1);
        rearm();

        // Player 1 runs to 9
        for (int n = 0; n < 9; n++) begin
            cyc(1'b0, 2'b10, 1'b0, "p1_point");
            if (n < 8) rearm();
        end
        chk("win_winner", int'(winner), 2);
        chk("win_over", int'(game_over), 1);
        chk("win_score", int'(scores), 8'h92);
        cyc(1'b0, 2'b00, 1'b1, "frozen");
        cyc(1'b0, 2'b10, 1'b0, "frozen");
        cyc(1'b0, 2'b01, 1'b1, "frozen");
        cyc(1'b0, 2'b00, 1'b0, "frozen");
        chk("frozen_score", int'(scores), 8'h92);
        chk("frozen_winner", int'(winner), 2);

        // Reset mid-PLAY with goal held
        cyc(1'b1, 2'b00, 1'b0, "rst");
        cyc(1'b0, 2'b00, 1'b1, "serve");
        cyc(1'b1, 2'b01, 1'b0, "rst_in_play");
        chk("rst_scores", int'(scores), 0);
        chk("rst_play", int'(in_play), 0);
        cyc(1'b0, 2'b01, 1'b0, "held_serve");
        cyc(1'b0, 2'b01, 1'b1, "held_serve");
        repeat (3) cyc(1'b0, 2'b01, 1'b0, "held_play");
        chk("held_no_score", int'(scores), 0);
        cyc(1'b0, 2'b00, 1'b0, "release");
        cyc(1'b0, 2'b01, 1'b0, "new_edge");
        chk("new_edge_score", int'(scores), 1);
        rearm();

        // 8-8, then player 0 scores
        cyc(1'b1, 2'b00, 1'b0, "rst");
        cyc(1'b0, 2'b00, 1'b1, "serve");
        for (int n = 0; n < 8; n++) begin
            point(2'b01);
            point(2'b10);
        end
        cyc(1'b0, 2'b01, 1'b0, "p0_9_8");
`ifdef PONG_WIN_BY_TWO_EN
        chk("by2_9_8_over", int'(game_over), 0);
        rearm();
        cyc(1'b0, 2'b01, 1'b0, "p0_10_8");
        chk("by2_10_8_winner", int'(winner), 1);
        chk("by2_10_8_over", int'(game_over), 1);

        // Saturation: 14-14 then player 0 hits 15
        cyc(1'b1, 2'b00, 1'b0, "rst");
        cyc(1'b0, 2'b00, 1'b1, "serve");
        for (int n = 0; n < 14; n++) begin
            point(2'b01);
            point(2'b10);
        end
        chk("sat_14_14_over", int'(game_over), 0);
        cyc(1'b0, 2'b01, 1'b0, "p0_15_14");
        chk("sat_winner", int'(winner), 1);
        chk("sat_score", int'(scores), 8'hEF);
`else
        chk("dflt_9_8_winner", int'(winner), 1);
        chk("dflt_9_8_over", int'(game_over), 1);
        chk("dflt_9_8_score", int'(scores), 8'h89);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
